// File: rtl/uart_pkg.sv
// uart_pkg: shared state type, register offsets and status bit positions for the UART transmitter.
package uart_pkg;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  localparam logic [1:0] ADDR_DATA = 2'b00;
  localparam logic [1:0] ADDR_STAT = 2'b10;
  localparam int ST_EMPTY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_BUSY = 2;
  localparam int ST_OVF = 3;
  localparam int CLKS_PER_BIT_DEF = 200;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: single-clock first-word-fall-through byte FIFO.
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [7:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic w_push, w_pop;
  assign full = r_cnt == (AW+1)'(FIFO_DEPTH);
  assign empty = r_cnt == '0;
  assign w_push = push & ~full;
  assign w_pop = pop & ~empty;
  assign dout = r_mem[r_rp];
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp] <= din;
  // Pointers wrap naturally because the depth is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
    end else begin
      r_wp <= r_wp + AW'(w_push);
      r_rp <= r_rp + AW'(w_pop);
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end
endmodule

// File: rtl/uart_tx_io.sv
// uart_tx_io: memory-mapped 8N1 UART transmitter with byte FIFO and pollable status word.
module uart_tx_io #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT_DEF,
  parameter int FIFO_DEPTH = 8,
  parameter logic [1:0] ADDR_DATA = uart_pkg::ADDR_DATA,
  parameter logic [1:0] ADDR_STAT = uart_pkg::ADDR_STAT
) (
  input  logic        uarttx_clk,
  input  logic        uarttxrst,
  input  logic        txwrite,
  input  logic        txread,
  input  logic        txcs,
  input  logic [1:0]  txaddr,
  input  logic [15:0] txwdata,
  output logic [15:0] txrdata,
  output logic        tx
);
  import uart_pkg::*;
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  tx_state_t r_state;
  logic [CW-1:0] r_baud;
  logic [2:0] r_bit;
  logic [7:0] r_shift;
  logic r_tx, r_ovf;
  logic w_push, w_clr, w_full, w_empty, w_pop, w_tick, w_busy, w_unused_hi;
  logic [7:0] w_head;
  logic [15:0] w_stat;
  assign w_push = txcs & txwrite & (txaddr == ADDR_DATA);
  assign w_clr = txcs & txwrite & (txaddr == ADDR_STAT) & txwdata[3];
  assign w_tick = r_baud == CW'(CLKS_PER_BIT - 1);
  assign w_busy = r_state != IDLE;
  assign w_pop = ~w_empty & ((r_state == IDLE) | ((r_state == STOP) & w_tick));
  assign w_unused_hi = ^txwdata[15:8];
  assign tx = r_tx;
  uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(uarttx_clk),
    .rst(uarttxrst),
    .push(w_push),
    .din(txwdata[7:0]),
    .pop(w_pop),
    .dout(w_head),
    .full(w_full),
    .empty(w_empty)
  );
  always_comb begin
    w_stat = '0;
    w_stat[ST_EMPTY] = w_empty;
    w_stat[ST_FULL] = w_full;
    w_stat[ST_BUSY] = w_busy;
    w_stat[ST_OVF] = r_ovf;
    txrdata = (txcs & txread & (txaddr == ADDR_STAT)) ? w_stat : 16'h0000;
  end
  // Overflow uses the pre-edge full flag, so a same-cycle pop cannot rescue the byte.
  always_ff @(posedge uarttx_clk) begin
    if (uarttxrst) begin
      r_state <= IDLE;
      r_baud <= '0;
      r_bit <= '0;
      r_shift <= '0;
      r_tx <= 1'b1;
      r_ovf <= 1'b0;
    end else begin
      r_ovf <= (w_push & w_full) | (r_ovf & ~w_clr);
      r_baud <= (r_state == IDLE || w_tick) ? '0 : r_baud + CW'(1);
      if (w_pop) r_shift <= w_head;
      case (r_state)
        IDLE:
          if (w_pop) begin
            r_state <= START;
            r_tx <= 1'b0;
          end
        START:
          if (w_tick) begin
            r_state <= DATA;
            r_bit <= '0;
            r_tx <= r_shift[0];
          end
        DATA:
          if (w_tick) begin
            r_shift <= r_shift >> 1;
            r_bit <= r_bit + 3'd1;
            r_state <= (r_bit == 3'd7) ? STOP : DATA;
            r_tx <= (r_bit == 3'd7) ? 1'b1 : r_shift[1];
          end
        default:
          if (w_tick) begin
            r_state <= w_pop ? START : IDLE;
            r_tx <= ~w_pop;
          end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_io.sv
// tb_uart_tx_io: directed bench for uart_tx_io with CLKS_PER_BIT=4 and FIFO_DEPTH=8.
module tb_uart_tx_io;
  import uart_pkg::*;
  localparam int CPB = 4;
  logic clk = 1'b0;
  logic rst, wr, rd, cs;
  logic [1:0] addr;
  logic [15:0] wdata, rdata;
  logic tx;
  int checks = 0;
  int errors = 0;
  logic [127:0] tx_v, busy_v;
  always #5 clk = ~clk;
  uart_tx_io #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(8)) dut (
    .uarttx_clk(clk),
    .uarttxrst(rst),
    .txwrite(wr),
    .txread(rd),
    .txcs(cs),
    .txaddr(addr),
    .txwdata(wdata),
    .txrdata(rdata),
    .tx(tx)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push(input logic [7:0] b);
    cs = 1'b1; wr = 1'b1; addr = ADDR_DATA; wdata = {8'h00, b};
    tick();
    cs = 1'b0; wr = 1'b0; wdata = 16'h0000;
  endtask
  task automatic write_stat(input logic [15:0] d);
    cs = 1'b1; wr = 1'b1; addr = ADDR_STAT; wdata = d;
    tick();
    cs = 1'b0; wr = 1'b0; wdata = 16'h0000;
  endtask
  task automatic read_stat(output logic [15:0] v);
    cs = 1'b1; rd = 1'b1; addr = ADDR_STAT;
    #1;
    v = rdata;
    cs = 1'b0; rd = 1'b0;
  endtask
  task automatic capture(input int n);
    tx_v = '0;
    busy_v = '0;
    cs = 1'b1; rd = 1'b1; addr = ADDR_STAT;
    for (int i = 0; i < n; i++) begin
      tick();
      tx_v[i] = tx;
      busy_v[i] = rdata[ST_BUSY];
    end
    cs = 1'b0; rd = 1'b0;
  endtask
  function automatic logic [79:0] expand(input logic [9:0] f);
    logic [79:0] r = '0;
    for (int i = 0; i < 10 * CPB; i++) r[i] = f[i / CPB];
    return r;
  endfunction
  task automatic rx_byte(output logic [7:0] b, output logic ok);
    int n = 0;
    b = '0;
    ok = 1'b0;
    while (tx !== 1'b0 && n < 500) begin
      tick();
      n++;
    end
    if (tx === 1'b0) begin
      repeat (CPB + 1) tick();
      for (int j = 0; j < 8; j++) begin
        b[j] = tx;
        repeat (CPB) tick();
      end
      ok = tx === 1'b1;
      repeat (2) tick();
    end
  endtask
  task automatic test_reset();
    logic [15:0] s;
    int bad = 0;
    rst = 1'b1; cs = 1'b0; wr = 1'b0; rd = 1'b0; addr = 2'b00; wdata = 16'h0000;
    tick();
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL reset_idle_tx low_cycles got %0d want 0", bad); end
    read_stat(s);
    checks++;
    if (s !== 16'h0001) begin errors++; $display("FAIL reset_status got %h want 0001", s); end
  endtask
  task automatic test_single_frame();
    logic [15:0] s;
    logic [79:0] e = expand(10'h2AA);
    push(8'h55);
    read_stat(s);
    checks++;
    if (s !== 16'h0000) begin errors++; $display("FAIL single_queued_status got %h want 0000", s); end
    capture(41);
    checks++;
    if (tx_v[40:0] !== {1'b1, e[39:0]}) begin errors++; $display("FAIL single_tx got %h want %h", tx_v[40:0], {1'b1, e[39:0]}); end
    checks++;
    if (busy_v[40:0] !== {1'b0, {40{1'b1}}}) begin errors++; $display("FAIL single_busy got %h want %h", busy_v[40:0], {1'b0, {40{1'b1}}}); end
    read_stat(s);
    checks++;
    if (s !== 16'h0001) begin errors++; $display("FAIL single_end_status got %h want 0001", s); end
  endtask
  task automatic test_back_to_back();
    logic [79:0] e1 = expand(10'h346);
    logic [79:0] e2 = expand(10'h21E);
    logic [79:0] e;
    e = {e2[39:0], e1[39:0]};
    push(8'hA3);
    push(8'h0F);
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL b2b_first_start got %b want 0", tx); end
    capture(80);
    checks++;
    if (tx_v[79:0] !== {1'b1, e[79:1]}) begin errors++; $display("FAIL b2b_tx got %h want %h", tx_v[79:0], {1'b1, e[79:1]}); end
    checks++;
    if (busy_v[79:0] !== {1'b0, {79{1'b1}}}) begin errors++; $display("FAIL b2b_busy got %h want %h", busy_v[79:0], {1'b0, {79{1'b1}}}); end
  endtask
  task automatic test_overflow();
    logic [15:0] s;
    logic [7:0] b;
    logic ok;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          push(8'h10 + 8'(i));
          if (i == 8) begin
            read_stat(s);
            checks++;
            if (s !== 16'h0006) begin errors++; $display("FAIL ovf_full_status got %h want 0006", s); end
          end
        end
        read_stat(s);
        checks++;
        if (s !== 16'h000E) begin errors++; $display("FAIL ovf_set_status got %h want 000e", s); end
        write_stat(16'h0008);
        read_stat(s);
        checks++;
        if (s !== 16'h0006) begin errors++; $display("FAIL ovf_clear_status got %h want 0006", s); end
      end
      begin
        for (int j = 0; j < 9; j++) begin
          rx_byte(b, ok);
          checks++;
          if (!ok || b !== 8'h10 + 8'(j)) begin errors++; $display("FAIL ovf_rx_byte%0d got %h ok=%b want %h", j, b, ok, 8'h10 + 8'(j)); end
        end
      end
    join
    repeat (3) tick();
    read_stat(s);
    checks++;
    if (s !== 16'h0001) begin errors++; $display("FAIL ovf_drained_status got %h want 0001", s); end
  endtask
  task automatic test_reset_mid_frame();
    logic [15:0] s;
    int bad = 0;
    push(8'h00);
    push(8'h11);
    push(8'h22);
    push(8'h33);
    repeat (14) tick();
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL midrst_in_bit3 got %b want 0", tx); end
    rst = 1'b1;
    tick();
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL midrst_tx got %b want 1", tx); end
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL midrst_no_frames low_cycles got %0d want 0", bad); end
    read_stat(s);
    checks++;
    if (s !== 16'h0001) begin errors++; $display("FAIL midrst_status got %h want 0001", s); end
  endtask
  task automatic test_decode();
    logic [15:0] s;
    int bad = 0;
    cs = 1'b1; rd = 1'b1; addr = ADDR_DATA;
    #1;
    checks++;
    if (rdata !== 16'h0000) begin errors++; $display("FAIL dec_read_data got %h want 0000", rdata); end
    cs = 1'b0; addr = ADDR_STAT;
    #1;
    checks++;
    if (rdata !== 16'h0000) begin errors++; $display("FAIL dec_read_nocs got %h want 0000", rdata); end
    rd = 1'b0;
    wr = 1'b1; addr = ADDR_DATA; wdata = 16'h005A;
    tick();
    cs = 1'b1; addr = 2'b01;
    tick();
    cs = 1'b0; wr = 1'b0; wdata = 16'h0000;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (tx !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL dec_no_frame low_cycles got %0d want 0", bad); end
    read_stat(s);
    checks++;
    if (s !== 16'h0001) begin errors++; $display("FAIL dec_status got %h want 0001", s); end
  endtask
  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_reset_mid_frame();
    test_decode();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
